fifo_ctrl: RTL and testbench
============================

FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 Parameter dep, 16, RAM depth in words; SHALL equal 2**add.
REQ-002 Parameter add, 4, RAM address width.
REQ-003 Parameter afull, 14, almost-full threshold (count >= afull).
REQ-004 Parameter aempty, 2, almost-empty threshold (count <= aempty).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 push  input  1  producer write request.
REQ-008 pop  input  1  consumer read request.
REQ-009 clr_err  input  1  synchronous clear of sticky error flags.
REQ-010 wr  output  1  write enable to dual_port_syn.
REQ-011 wa  output  add  write address to dual_port_syn.
REQ-012 rd  output  1  read enable to dual_port_syn.
REQ-013 ra  output  add  read address to dual_port_syn.
REQ-014 dvalid  output  1  dual_port_syn dout valid this cycle.
REQ-015 count  output  add+1  current occupancy, 0..dep.
REQ-016 full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-017 ovf, udf  output  1 each  sticky overflow / underflow flags.

Function
REQ-018 Push accept SHALL be push && !full; pop accept SHALL be pop && !empty; both use the registered flags of the current cycle.
REQ-019 wr SHALL equal push accept and rd SHALL equal pop accept, combinationally, same cycle.
REQ-020 wa SHALL equal the write pointer; ra SHALL equal the read pointer; both driven from registers.
REQ-021 On accepted push, the write pointer SHALL increment by 1 at the clock edge, wrapping dep-1 -> 0.
REQ-022 On accepted pop, the read pointer SHALL increment by 1 at the clock edge, wrapping dep-1 -> 0.
REQ-023 count SHALL be +1 on push-only accept, -1 on pop-only accept, and unchanged on both or neither.
REQ-024 full SHALL be registered as (next count == dep); empty SHALL be registered as (next count == 0).
REQ-025 almost_full SHALL be registered as (next count >= afull); almost_empty SHALL be registered as (next count <= aempty).
REQ-026 dvalid SHALL be asserted exactly one cycle after rd, matching the 1-cycle RAM read latency.
REQ-027 Push while empty with pop: push SHALL be accepted, pop rejected, and udf set; count becomes 1.
REQ-028 Push while full with pop: pop SHALL be accepted, push rejected, and ovf set; count stays dep-1 next cycle.
REQ-029 ovf SHALL set on push && full; udf SHALL set on pop && empty; both SHALL hold until clr_err.
REQ-030 clr_err SHALL clear ovf/udf at the edge; a same-cycle new error SHALL win (flag stays 1).
REQ-031 A rejected request SHALL NOT change pointers, count, or flags other than ovf/udf.

Reset
REQ-032 rst low SHALL immediately clear both pointers, count, full, dvalid, ovf, and udf, and set empty and almost_empty; almost_full SHALL be 0.
REQ-033 While rst is low, wr and rd SHALL be forced to 0, independent of push and pop.
REQ-034 Reset asserted mid-burst SHALL discard FIFO contents; the first push after release SHALL write address 0.

Structure
REQ-035 Defaults for dep, add, afull, and aempty SHALL live in shared package fifo_pkg, reused by dual_port_syn wrappers.
REQ-036 The write and read pointers SHALL each be an instance of sub-module wrap_ptr (enable-increment, modulo dep, async active-low clear).
REQ-037 fifo_ctrl together with dual_port_syn SHALL form a complete synchronous FIFO; fifo_ctrl SHALL hold no data storage.

Verification
REQ-038 Reset, then 16 pushes -> wa 0..15, count 16, full=1, almost_full=1 from count 14, empty=0.
REQ-039 From full, a 17th push -> wr=0, ovf=1, count stays 16; then clr_err -> ovf=0.
REQ-040 16 pops from full -> ra 0..15, dvalid one cycle after each rd, and dout order matches push order; empty=1 at end.
REQ-041 Pop on empty -> rd=0, udf=1; push+pop on empty -> count 1, udf=1.
REQ-042 Wrap check: 10 pushes and 10 pops, then 10 pushes -> wa wraps 15 -> 0 (writes at addresses 10..15, 0..3); simultaneous push+pop at count 8 -> count stays 8.
REQ-043 rst low mid-burst at count 5 -> count 0, empty=1, wr=rd=0 immediately; the first push after release -> wa=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO sizing defaults, used by fifo_ctrl and the dual_port_syn wrappers.
package fifo_pkg;
  localparam int DEP    = 16;  // RAM depth in words, always 2**ADD
  localparam int ADD    = 4;   // RAM address width
  localparam int AFULL  = 14;  // almost_full when count >= AFULL
  localparam int AEMPTY = 2;   // almost_empty when count <= AEMPTY
endpackage

// File: rtl/wrap_ptr.sv
// Enable-increment pointer that wraps dep-1 -> 0, with async active-low clear.
module wrap_ptr
  import fifo_pkg::*;
#(
  parameter int dep = DEP,
  parameter int add = ADD
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  output logic [add-1:0] ptr
);

  localparam logic [add-1:0] LAST = add'(dep - 1);

  logic [add-1:0] ptr_q, ptr_d;

  // Next pointer: advance on enable, wrap after the last RAM word.
  always_comb begin
    ptr_d = ptr_q;
    if (en) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + add'(1);
    end
  end

  // Pointer register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller: pointers, occupancy, status and sticky error
// flags for an external dual_port_syn RAM. Holds no data itself.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int dep    = DEP,
  parameter int add    = ADD,
  parameter int afull  = AFULL,
  parameter int aempty = AEMPTY
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic           pop,
  input  logic           clr_err,
  output logic           wr,
  output logic [add-1:0] wa,
  output logic           rd,
  output logic [add-1:0] ra,
  output logic           dvalid,
  output logic [add:0]   count,
  output logic           full,
  output logic           empty,
  output logic           almost_full,
  output logic           almost_empty,
  output logic           ovf,
  output logic           udf
);

  localparam int CW = add + 1;
  localparam logic [add:0] DEP_C    = CW'(dep);
  localparam logic [add:0] AFULL_C  = CW'(afull);
  localparam logic [add:0] AEMPTY_C = CW'(aempty);

  logic           push_acc, pop_acc;
  logic [add:0]   count_q, count_d;
  logic           full_q, full_d, empty_q, empty_d;
  logic           afull_q, afull_d, aempty_q, aempty_d;
  logic           dvalid_q;
  logic           ovf_q, ovf_d, udf_q, udf_d;

  // Accept decisions use this cycle's registered flags; reset blocks RAM access.
  assign push_acc = rst & push & ~full_q;
  assign pop_acc  = rst & pop & ~empty_q;

  wrap_ptr #(.dep(dep), .add(add)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .en  (push_acc),
    .ptr (wa)
  );

  wrap_ptr #(.dep(dep), .add(add)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .en  (pop_acc),
    .ptr (ra)
  );

  // Next occupancy and the flags derived from it; errors are sticky until
  // clr_err, and a fresh error in the clearing cycle keeps the flag set.
  always_comb begin
    count_d = count_q;
    case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d   = (count_d == DEP_C);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AFULL_C);
    aempty_d = (count_d <= AEMPTY_C);
    ovf_d    = (push & full_q) | (ovf_q & ~clr_err);
    udf_d    = (pop & empty_q) | (udf_q & ~clr_err);
  end

  // Status registers; dvalid trails rd by the one-cycle RAM read latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      dvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      dvalid_q <= pop_acc;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign wr           = push_acc;
  assign rd           = pop_acc;
  assign dvalid       = dvalid_q;
  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign ovf          = ovf_q;
  assign udf          = udf_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl with a simple 1-cycle-latency RAM and a queue-based
// reference FIFO.
module tb_fifo_ctrl;
  import fifo_pkg::*;

  localparam int D = DEP;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       push = 1'b0, pop = 1'b0, clr_err = 1'b0;
  logic       wr, rd, dvalid, full, empty, almost_full, almost_empty, ovf, udf;
  logic [3:0] wa, ra;
  logic [4:0] count;

  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic [7:0] mem [D];

  int errors = 0;
  int checks = 0;

  logic [7:0] q[$];
  int         n_push, n_pop;
  logic       ovf_m, udf_m, dv_m;
  logic [7:0] dout_exp;

  fifo_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .pop          (pop),
    .clr_err      (clr_err),
    .wr           (wr),
    .wa           (wa),
    .rd           (rd),
    .ra           (ra),
    .dvalid       (dvalid),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .ovf          (ovf),
    .udf          (udf)
  );

  always #5 clk = ~clk;

  // dual_port_syn stand-in: synchronous write, registered read.
  always @(posedge clk) begin
    if (wr) mem[wa] <= din;
    if (rd) dout <= mem[ra];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    n_push = 0;
    n_pop  = 0;
    ovf_m  = 1'b0;
    udf_m  = 1'b0;
    dv_m   = 1'b0;
  endtask

  task automatic check_state(input logic ap, input logic apo);
    chk("wr", 32'(wr), 32'(ap));
    chk("rd", 32'(rd), 32'(apo));
    chk("wa", 32'(wa), 32'(n_push % D));
    chk("ra", 32'(ra), 32'(n_pop % D));
    chk("count", 32'(count), 32'(q.size()));
    chk("full", 32'(full), 32'(q.size() == D));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("almost_full", 32'(almost_full), 32'(q.size() >= AFULL));
    chk("almost_empty", 32'(almost_empty), 32'(q.size() <= AEMPTY));
    chk("ovf", 32'(ovf), 32'(ovf_m));
    chk("udf", 32'(udf), 32'(udf_m));
    chk("dvalid", 32'(dvalid), 32'(dv_m));
    if (dv_m) chk("dout", 32'(dout), 32'(dout_exp));
  endtask

  // One clock cycle: drive at negedge, check before the edge, advance model after.
  task automatic step(input logic p, input logic po, input logic ce);
    logic ap, apo, was_full, was_empty;
    logic [7:0] d;
    @(negedge clk);
    d       = 8'($urandom);
    push    = p;
    pop     = po;
    clr_err = ce;
    din     = d;
    #1;
    was_full  = (q.size() == D);
    was_empty = (q.size() == 0);
    ap  = rst && p && !was_full;
    apo = rst && po && !was_empty;
    check_state(ap, apo);
    @(posedge clk);
    #1;
    if (!rst) begin
      model_reset();
    end else begin
      if (apo) begin
        dout_exp = q.pop_front();
        n_pop++;
      end
      if (ap) begin
        q.push_back(d);
        n_push++;
      end
      dv_m  = apo;
      ovf_m = (p && was_full)   ? 1'b1 : (ce ? 1'b0 : ovf_m);
      udf_m = (po && was_empty) ? 1'b1 : (ce ? 1'b0 : udf_m);
    end
  endtask

  // Assert reset away from any clock edge and check its immediate effect.
  task automatic async_reset();
    @(negedge clk);
    #2;
    rst  = 1'b0;
    push = 1'b1;
    pop  = 1'b1;
    #1;
    model_reset();
    check_state(1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    dout_exp = 8'h00;

    // Reset state, requests ignored while in reset.
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    rst = 1'b1;

    // Fill to full, then overflow and clear.
    repeat (16) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    // Drain, checking read order and dvalid latency.
    repeat (16) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Underflow, push+pop on empty, clear racing a new error.
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);

    // Push+pop while full.
    repeat (16) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    // Pointer wrap from a clean start, then push+pop at count 8.
    async_reset();
    step(1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    repeat (10) step(1'b1, 1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b1, 1'b0);
    repeat (10) step(1'b1, 1'b0, 1'b0);
    repeat (2)  step(1'b0, 1'b1, 1'b0);
    repeat (3)  step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Reset in the middle of a burst at count 5.
    async_reset();
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (5) step(1'b1, 1'b0, 1'b0);
    async_reset();
    step(1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Random traffic: producer-heavy, then consumer-heavy.
    repeat (200) step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 40,
                      $urandom_range(0, 99) < 5);
    repeat (200) step($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 65,
                      $urandom_range(0, 99) < 5);
    step(1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
